// File: rtl/trail_pkg.sv
// Shared trail frame-buffer definitions: geometry defaults, trail code encoding,
// fetch FSM states and nibble extraction. Also used by the trail writer.
package trail_pkg;

  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned V_ACTIVE_DEF = 480;
  localparam int unsigned WPL_DEF      = H_ACTIVE_DEF / 4;

  typedef enum logic [3:0] {
    NONE    = 4'd0,
    B_HORIZ = 4'd1,
    B_VERT  = 4'd2,
    R_HORIZ = 4'd3,
    R_VERT  = 4'd4,
    CORNER  = 4'd5
  } trail_code_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } fetch_state_t;

  // Pixel x occupies nibble x[1:0] of its word, pixel 0 in bits [3:0].
  function automatic logic [3:0] code_at(input logic [15:0] word, input logic [1:0] xlo);
    return word[{xlo, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/trail_fb_reader_if.sv
// OCM read port of the trail frame buffer: word address, read strobe and
// fixed-latency read data.
interface trail_fb_reader_if;
  logic [19:0] fb_addr;
  logic        fb_re;
  logic [15:0] fb_rdata;

  modport master (output fb_addr, output fb_re, input fb_rdata);
  modport slave  (input fb_addr, input fb_re, output fb_rdata);
endinterface

// File: rtl/trail_line_buf.sv
// Ping-pong scanline buffer: simple dual-port synchronous RAM of 2*WPL 16-bit
// words, addressed as {half, word index}, with a one-cycle registered read.
module trail_line_buf #(
  parameter  int unsigned WPL = 160,
  localparam int unsigned IW  = $clog2(WPL),
  localparam int unsigned AW  = $clog2(2 * WPL)
) (
  input  logic          Clk,
  input  logic          we,
  input  logic          wr_half,
  input  logic [IW-1:0] wr_idx,
  input  logic [15:0]   wr_data,
  input  logic          rd_half,
  input  logic [IW-1:0] rd_idx,
  output logic [15:0]   rd_data
);

  logic [15:0]   mem [2 * WPL];
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] rd_addr;

  // Halves are packed back to back so the RAM is exactly 2*WPL deep.
  assign wr_addr = wr_half ? AW'(WPL) + AW'(wr_idx) : AW'(wr_idx);
  assign rd_addr = rd_half ? AW'(WPL) + AW'(rd_idx) : AW'(rd_idx);

  always_ff @(posedge Clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/trail_fb_reader.sv
// Read side of the trail frame buffer: prefetches the next scanline from OCM into
// a ping-pong line buffer during blanking and streams one trail code per pixel.
module trail_fb_reader
  import trail_pkg::*;
#(
  parameter int unsigned H_ACTIVE  = H_ACTIVE_DEF,
  parameter int unsigned V_ACTIVE  = V_ACTIVE_DEF,
  parameter int unsigned RD_LAT    = 2,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              pix_ce,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  trail_fb_reader_if.master fb,
  output logic [3:0]        trail_code,
  output logic              code_valid,
  output logic              underrun
);

  localparam int unsigned WPL = H_ACTIVE / 4;
  localparam int unsigned IW  = $clog2(WPL);

  fetch_state_t      state;
  fetch_state_t      state_nx;
  logic [IW-1:0]     w;
  logic [19:0]       line_base;
  logic              line_ready;
  logic              disp_sel;
  logic [RD_LAT-1:0] tag_v;
  logic [IW-1:0]     tag_idx [RD_LAT];

  logic              in_x;
  logic              in_y;
  logic              trigger;
  logic              swap;
  logic              last_w;
  logic              issue;
  logic [9:0]        target;
  logic [IW-1:0]     rd_idx;
  logic [15:0]       rd_word;

  logic              s1_ce;
  logic              s1_act;
  logic [1:0]        s1_xlo;

  assign in_x    = DrawX < 10'(H_ACTIVE);
  assign in_y    = DrawY < 10'(V_ACTIVE);
  assign trigger = pix_ce && (DrawX == 10'(H_ACTIVE)) && in_y;
  assign swap    = pix_ce && (DrawX == '0) && in_y;
  assign target  = (DrawY == 10'(V_ACTIVE - 1)) ? '0 : DrawY + 10'd1;
  assign last_w  = (w == IW'(WPL - 1));
  assign issue   = (state == ISSUE);

  assign fb.fb_re   = issue;
  assign fb.fb_addr = issue ? line_base + 20'(w) : '0;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (trigger) state_nx = ISSUE;
      ISSUE:   if (last_w) state_nx = DRAIN;
      DRAIN:   if (tag_v == '0) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      w          <= '0;
      line_base  <= '0;
      line_ready <= 1'b0;
      disp_sel   <= 1'b0;
      underrun   <= 1'b0;
      tag_v      <= '0;
      for (int unsigned i = 0; i < RD_LAT; i++) begin
        tag_idx[i] <= '0;
      end
    end else begin
      if (state == IDLE && trigger) begin
        line_base  <= 20'(BASE_ADDR) + 20'(target) * 20'(WPL);
        w          <= '0;
        line_ready <= 1'b0;
      end else if (issue) begin
        w <= w + IW'(1);
      end
      if (state == DONE) begin
        line_ready <= 1'b1;
      end
      // Tag pipeline mirrors the OCM latency so each return lands at its word index.
      tag_v[0]   <= issue;
      tag_idx[0] <= w;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        tag_v[i]   <= tag_v[i-1];
        tag_idx[i] <= tag_idx[i-1];
      end
      if (swap) begin
        disp_sel <= ~disp_sel;
        if (!line_ready) begin
          underrun <= 1'b1;
        end
      end
    end
  end

  // Pixel 0 is read in the same cycle as the swap, so it must address the new half.
  assign rd_idx = in_x ? IW'(DrawX[9:2]) : '0;

  trail_line_buf #(
    .WPL(WPL)
  ) u_line_buf (
    .Clk     (Clk),
    .we      (tag_v[RD_LAT-1]),
    .wr_half (~disp_sel),
    .wr_idx  (tag_idx[RD_LAT-1]),
    .wr_data (fb.fb_rdata),
    .rd_half (disp_sel ^ swap),
    .rd_idx  (rd_idx),
    .rd_data (rd_word)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      s1_ce      <= 1'b0;
      s1_act     <= 1'b0;
      s1_xlo     <= '0;
      trail_code <= '0;
      code_valid <= 1'b0;
    end else begin
      s1_ce  <= pix_ce;
      s1_act <= pix_ce && in_x && in_y;
      s1_xlo <= DrawX[1:0];
      if (s1_ce) begin
        trail_code <= s1_act ? code_at(rd_word, s1_xlo) : '0;
        code_valid <= s1_act;
      end
    end
  end

endmodule

// File: tb/tb_trail_fb_reader.sv
// Directed bench for trail_fb_reader: a default-geometry instance for reset, prefetch,
// pixel order, wrap and underrun; three small-geometry instances for the latency sweep.
module tb_trail_fb_reader;

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b0;
  logic       pix_ce = 1'b0;
  logic [9:0] draw_x = '0;
  logic [9:0] draw_y = '0;

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  // Default-geometry instance, OCM latency 2: line 0 holds 16'h0150, all other lines 16'h5432.
  trail_fb_reader_if mif ();
  logic [15:0] mpipe [2];
  logic [3:0]  m_code;
  logic        m_valid;
  logic        m_unr;

  function automatic logic [15:0] ocm_word(input logic [19:0] a);
    return (a < 20'd160) ? 16'h0150 : 16'h5432;
  endfunction

  always @(posedge clk) begin
    mpipe[0] <= mif.fb_re ? ocm_word(mif.fb_addr) : 16'hDEAD;
    mpipe[1] <= mpipe[0];
  end
  assign mif.fb_rdata = mpipe[1];

  trail_fb_reader #(
    .H_ACTIVE  (640),
    .V_ACTIVE  (480),
    .RD_LAT    (2),
    .BASE_ADDR (0)
  ) u_main (
    .Clk        (clk),
    .Reset_n    (rst_n),
    .pix_ce     (pix_ce),
    .DrawX      (draw_x),
    .DrawY      (draw_y),
    .fb         (mif),
    .trail_code (m_code),
    .code_valid (m_valid),
    .underrun   (m_unr)
  );

  // Read-port monitor: cumulative counters, sampled on the falling edge.
  int unsigned re_cnt   = 0;
  int unsigned bursts   = 0;
  int unsigned addr_err = 0;
  logic [19:0] burst_first = '0;
  logic [19:0] last_addr   = '0;
  logic        prev_re     = 1'b0;

  always @(negedge clk) begin
    if (mif.fb_re) begin
      if (!prev_re) begin
        bursts++;
        burst_first = mif.fb_addr;
      end else if (mif.fb_addr != last_addr + 20'd1) begin
        addr_err++;
      end
      re_cnt++;
      last_addr = mif.fb_addr;
    end
    prev_re = mif.fb_re;
  end

  // Sweep instances: 32x4 active, 48x6 total, OCM latency 1, 2 and 4.
  logic [15:0] sw_mem [32];
  logic [3:0]  sw_code  [3];
  logic        sw_valid [3];
  logic        sw_unr   [3];

  for (genvar g = 0; g < 3; g++) begin : g_sw
    localparam int unsigned LAT = (g == 0) ? 1 : (g == 1) ? 2 : 4;
    trail_fb_reader_if sif ();
    logic [15:0] pipe [LAT];

    always @(posedge clk) begin
      pipe[0] <= sif.fb_re ? sw_mem[sif.fb_addr[4:0]] : 16'hDEAD;
      for (int i = 1; i < LAT; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
    assign sif.fb_rdata = pipe[LAT-1];

    trail_fb_reader #(
      .H_ACTIVE  (32),
      .V_ACTIVE  (4),
      .RD_LAT    (LAT),
      .BASE_ADDR (0)
    ) u_dut (
      .Clk        (clk),
      .Reset_n    (rst_n),
      .pix_ce     (pix_ce),
      .DrawX      (draw_x),
      .DrawY      (draw_y),
      .fb         (sif),
      .trail_code (sw_code[g]),
      .code_valid (sw_valid[g]),
      .underrun   (sw_unr[g])
    );
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One VGA pixel: pix_ce high for one Clk, then one idle Clk.
  task automatic pix(input int unsigned x, input int unsigned y);
    draw_x = 10'(x);
    draw_y = 10'(y);
    pix_ce = 1'b1;
    tick();
    pix_ce = 1'b0;
    tick();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int unsigned r0;
    int unsigned b0;
    int unsigned e0;
    logic [3:0]  l0 [4];
    logic [15:0] wv;
    logic [3:0]  ec;
    logic        ev;

    l0[0] = 4'd0; l0[1] = 4'd5; l0[2] = 4'd1; l0[3] = 4'd0;

    // Reset state
    repeat (3) tick();
    check("rst_fb_addr", 32'(mif.fb_addr), 32'd0);
    check("rst_fb_re", 32'(mif.fb_re), 32'd0);
    check("rst_trail_code", 32'(m_code), 32'd0);
    check("rst_code_valid", 32'(m_valid), 32'd0);
    check("rst_underrun", 32'(m_unr), 32'd0);
    rst_n = 1'b1;
    tick();

    // Reset mid-ISSUE
    pix(640, 10);
    repeat (3) tick();
    check("issue_fb_re", 32'(mif.fb_re), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_fb_re", 32'(mif.fb_re), 32'd0);
    check("midrst_fb_addr", 32'(mif.fb_addr), 32'd0);
    check("midrst_code_valid", 32'(m_valid), 32'd0);
    check("midrst_underrun", 32'(m_unr), 32'd0);
    rst_n = 1'b1;
    r0 = re_cnt;
    repeat (20) tick();
    check("postrst_no_reads", re_cnt - r0, 32'd0);

    // Prefetch of line 11
    r0 = re_cnt; b0 = bursts; e0 = addr_err;
    for (int unsigned x = 640; x < 800; x++) pix(x, 10);
    check("pf11_count", re_cnt - r0, 32'd160);
    check("pf11_bursts", bursts - b0, 32'd1);
    check("pf11_first", 32'(burst_first), 32'd1760);
    check("pf11_last", 32'(last_addr), 32'd1919);
    check("pf11_seq", addr_err - e0, 32'd0);
    check("pf11_line_ready", 32'(u_main.line_ready), 32'd1);

    // Line 11 pixel order, with exact two-cycle latency on pixel 0
    draw_x = 10'd0;
    draw_y = 10'd11;
    pix_ce = 1'b1;
    tick();
    pix_ce = 1'b0;
    check("lat_hold_valid", 32'(m_valid), 32'd0);
    tick();
    check("lat_code_x0", 32'(m_code), 32'd2);
    check("lat_valid_x0", 32'(m_valid), 32'd1);
    for (int unsigned x = 1; x < 800; x++) begin
      pix(x, 11);
      check($sformatf("l11_code_x%0d", x), 32'(m_code), (x < 640) ? 32'(2 + x % 4) : 32'd0);
      check($sformatf("l11_valid_x%0d", x), 32'(m_valid), (x < 640) ? 32'd1 : 32'd0);
    end
    check("l11_underrun", 32'(m_unr), 32'd0);

    // Wrap: line 479 prefetches line 0, then vertical blanking
    r0 = re_cnt; b0 = bursts;
    for (int unsigned x = 640; x < 800; x++) pix(x, 479);
    check("wrap_count", re_cnt - r0, 32'd160);
    check("wrap_bursts", bursts - b0, 32'd1);
    check("wrap_first", 32'(burst_first), 32'd0);
    check("wrap_last", 32'(last_addr), 32'd159);
    r0 = re_cnt;
    for (int unsigned y = 480; y < 525; y++) begin
      pix(0, y);
      check($sformatf("vbl_valid_y%0d", y), 32'(m_valid), 32'd0);
      pix(320, y);
      pix(640, y);
      pix(799, y);
    end
    check("vbl_no_reads", re_cnt - r0, 32'd0);
    for (int unsigned x = 0; x < 800; x++) begin
      pix(x, 0);
      check($sformatf("l0_code_x%0d", x), 32'(m_code), (x < 640) ? 32'(l0[x % 4]) : 32'd0);
      check($sformatf("l0_valid_x%0d", x), 32'(m_valid), (x < 640) ? 32'd1 : 32'd0);
    end
    check("l0_underrun", 32'(m_unr), 32'd0);

    // Underrun: swap arrives two Clk after the trigger of its line
    pix(0, 1);
    check("ur_before_1", 32'(m_unr), 32'd0);
    pix(640, 1);
    check("ur_before_2", 32'(m_unr), 32'd0);
    pix(0, 2);
    check("ur_set", 32'(m_unr), 32'd1);
    repeat (200) tick();
    pix(640, 2);
    repeat (200) tick();
    pix(0, 3);
    check("ur_good_code", 32'(m_code), 32'd2);
    check("ur_good_valid", 32'(m_valid), 32'd1);
    check("ur_sticky", 32'(m_unr), 32'd1);
    rst_n = 1'b0;
    #1;
    check("ur_cleared", 32'(m_unr), 32'd0);

    // Sweep: random contents, latencies 1/2/4, two full small frames
    for (int unsigned i = 0; i < 32; i++) sw_mem[i] = 16'($urandom);
    tick();
    rst_n = 1'b1;
    tick();
    for (int unsigned x = 32; x < 48; x++) pix(x, 3);
    for (int unsigned y = 4; y < 6; y++)
      for (int unsigned x = 0; x < 48; x++) pix(x, y);
    for (int unsigned f = 0; f < 2; f++) begin
      for (int unsigned y = 0; y < 6; y++) begin
        for (int unsigned x = 0; x < 48; x++) begin
          pix(x, y);
          ev = (x < 32) && (y < 4);
          wv = ev ? sw_mem[y * 8 + x / 4] : 16'h0000;
          ec = ev ? wv[4 * (x % 4) +: 4] : 4'h0;
          for (int unsigned g = 0; g < 3; g++) begin
            check($sformatf("sw%0d_code_f%0d_x%0d_y%0d", g, f, x, y), 32'(sw_code[g]), 32'(ec));
            check($sformatf("sw%0d_valid_f%0d_x%0d_y%0d", g, f, x, y), 32'(sw_valid[g]), 32'(ev));
          end
        end
      end
    end
    for (int unsigned g = 0; g < 3; g++) begin
      check($sformatf("sw%0d_underrun", g), 32'(sw_unr[g]), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
